// File: rtl/labfinalsoc_onchip_word_poller.sv
// Avalon-MM read master: sweeps a latency-1 RAM and streams each word with its index (3 cycles/word, stalls in HOLD on out_ready=0).
// Optional POLLER_CHANGE_DETECT_EN: words unchanged since their last handshake are skipped silently.
module labfinalsoc_onchip_word_poller #(
  parameter int NUM_WORDS  = 4,
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 32,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipsel,
  output logic              mem_write,
  output logic [3:0]        mem_byteen,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_HOLD} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   out_index_q, out_index_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic                advance;
  logic                skip;

`ifdef POLLER_CHANGE_DETECT_EN
  logic [DATA_W-1:0]    shadow_q [NUM_WORDS];
  logic [DATA_W-1:0]    shadow_d [NUM_WORDS];
  logic [NUM_WORDS-1:0] seen_q, seen_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    advance     = 1'b0;
    skip        = 1'b0;
`ifdef POLLER_CHANGE_DETECT_EN
    shadow_d = shadow_q;
    seen_d   = seen_q;
    skip     = seen_q[idx_q] && (mem_rdata == shadow_q[idx_q]);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPT;
      S_CAPT: begin
        if (skip) begin
          advance = 1'b1;
        end else begin
          out_data_d  = mem_rdata;
          out_index_d = idx_q;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          advance     = 1'b1;
`ifdef POLLER_CHANGE_DETECT_EN
          shadow_d[out_index_q] = out_data_q;
          seen_d[out_index_q]   = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A skipped word and a handshaken word move the sweep on identically.
    if (advance) begin
      if (idx_q != LAST_IDX) begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = S_ISSUE;
      end else begin
        done_d  = 1'b1;
        idx_d   = '0;
        state_d = CONTINUOUS ? S_ISSUE : S_IDLE;
      end
    end

    // Abort drops any pending word without recording it as delivered.
    if (abort) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
`ifdef POLLER_CHANGE_DETECT_EN
      shadow_d = shadow_q;
      seen_d   = seen_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

`ifdef POLLER_CHANGE_DETECT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WORDS; i++) shadow_q[i] <= '0;
      seen_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      seen_q   <= seen_d;
    end
  end
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign mem_address = idx_q;
  assign mem_chipsel = (state_q == S_ISSUE);
  assign mem_clken   = (state_q == S_ISSUE);
  assign mem_write   = 1'b0;
  assign mem_byteen  = 4'hF;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;

endmodule

// File: tb/tb_labfinalsoc_onchip_word_poller.sv
// Bench for labfinalsoc_onchip_word_poller: cycle table on a one-shot instance, continuous-mode sweep,
// async reset in CAPT, and randomized sweeps scored against a sweep-level reference model.
module tb_labfinalsoc_onchip_word_poller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // one-shot instance
  logic        start0 = 0, abort0 = 0, ready0 = 0;
  logic        busy0, done0, chipsel0, write0, clken0, valid0;
  logic [1:0]  addr0, index0;
  logic [3:0]  byteen0;
  logic [31:0] rdata0, data0;
  logic [31:0] ram0 [4];

  // continuous instance
  logic        start1 = 0, abort1 = 0, ready1 = 0;
  logic        busy1, done1, chipsel1, write1, clken1, valid1;
  logic [1:0]  addr1, index1;
  logic [3:0]  byteen1;
  logic [31:0] rdata1, data1;
  logic [31:0] ram1 [4];

  labfinalsoc_onchip_word_poller #(.CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
    .mem_address(addr0), .mem_chipsel(chipsel0), .mem_write(write0), .mem_byteen(byteen0),
    .mem_clken(clken0), .mem_rdata(rdata0), .out_valid(valid0), .out_ready(ready0),
    .out_data(data0), .out_index(index0));

  labfinalsoc_onchip_word_poller #(.CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .mem_address(addr1), .mem_chipsel(chipsel1), .mem_write(write1), .mem_byteen(byteen1),
    .mem_clken(clken1), .mem_rdata(rdata1), .out_valid(valid1), .out_ready(ready1),
    .out_data(data1), .out_index(index1));

  // latency-1 on-chip RAMs
  always @(posedge clk) if (clken0 && chipsel0) rdata0 <= ram0[addr0];
  always @(posedge clk) if (clken1 && chipsel1) rdata1 <= ram1[addr1];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] tag, input int i);
    logic [7:0] lo;
    lo = 8'hA0 + 8'(8'h11 * i);
    return {tag, 16'h0000, lo};
  endfunction

  typedef struct {
    logic        st, ab, rdy;
    logic [7:0]  tag;      // nonzero: load RAM with this sweep's pattern before applying
    logic        busy, vld, done, clken;
    logic [31:0] dat;
    logic [1:0]  idx;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic st, ab, rdy, input logic [7:0] tag,
                     input logic busy, vld, done, clken, input logic [31:0] dat, input logic [1:0] idx);
    vec_t v;
    v.st = st; v.ab = ab; v.rdy = rdy; v.tag = tag;
    v.busy = busy; v.vld = vld; v.done = done; v.clken = clken; v.dat = dat; v.idx = idx;
    vecs.push_back(v);
  endtask

  // ISSUE, CAPT, optional stall cycles, then the handshake cycle
  task automatic add_word(input logic [7:0] tag, input int i, input int stall, input logic st_ign);
    add(st_ign, 0, 1, 0, 1, 0, 0, 1, 0, 2'(i));
    add(st_ign, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int s = 0; s < stall; s++) add(0, 0, 0, 0, 1, 1, 0, 0, word_of(tag, i), 2'(i));
    add(0, 0, 1, 0, 1, 1, 0, 0, word_of(tag, i), 2'(i));
  endtask

  task automatic add_sweep(input logic [7:0] tag, input int stall_idx, input int stall_n, input logic st_ign);
    add(1, 0, 1, tag, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add_word(tag, i, (i == stall_idx) ? stall_n : 0, st_ign);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
  endtask

  // sweep-level reference: which words a sweep must deliver, in order
  logic [31:0] m_shadow [4];
  bit          m_seen   [4];
  logic [33:0] exp_q[$];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin m_seen[i] = 0; m_shadow[i] = '0; end
  endtask

  task automatic plan_sweep();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
`ifdef POLLER_CHANGE_DETECT_EN
      if (m_seen[i] && m_shadow[i] == ram0[i]) continue;
      m_seen[i] = 1; m_shadow[i] = ram0[i];
`endif
      exp_q.push_back({2'(i), ram0[i]});
    end
  endtask

  task automatic run_sweep0(input bit rnd_rdy, input string nm);
    int          dn;
    int          cyc;
    bit          held;
    logic [33:0] held_w;
    logic [33:0] e;
    dn = 0; held = 0; held_w = '0;
    @(negedge clk); start0 = 1; ready0 = 1;
    @(negedge clk); start0 = 0;
    for (cyc = 0; cyc < 300; cyc++) begin
      ready0 = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (held) chk({nm, " stall hold"}, {valid0, index0, data0}, {1'b1, held_w});
      held = 0;
      if (valid0) begin
        if (ready0) begin
          chk({nm, " word expected"}, 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({nm, " word"}, {index0, data0}, e);
          end
        end else begin
          held = 1; held_w = {index0, data0};
        end
      end
      if (done0) begin dn++; break; end
      @(negedge clk);
    end
    chk({nm, " done pulses"}, dn, 1);
    chk({nm, " words left over"}, exp_q.size(), 0);
    chk({nm, " busy at done"}, busy0, 0);
    @(negedge clk);
    chk({nm, " done one cycle"}, done0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [33:0] e1[$];
    logic [33:0] got1[$];
    int          hs, dn;

    for (int i = 0; i < 4; i++) begin ram0[i] = '0; ram1[i] = '0; end
    model_clear();

    // cycle table: plain sweep, stalled sweep with ignored starts, start+abort, abort in HOLD
    add_sweep(8'h01, -1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add_sweep(8'h02, 1, 5, 1);
    add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 8'h03, 0, 0, 0, 0, 0, 0);
    add_word(8'h03, 0, 0, 0);
    add_word(8'h03, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 1, 0, 2);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0, 0, word_of(8'h03, 2), 2);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add_sweep(8'h04, -1, 0, 0);

    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("reset busy0", busy0, 0);
    chk("reset done0", done0, 0);
    chk("reset valid0", valid0, 0);
    chk("reset clken/chipsel0", {clken0, chipsel0}, 0);
    chk("reset addr0/index0", {addr0, index0}, 0);
    chk("reset data0", data0, 0);
    chk("reset busy1/valid1", {busy1, valid1}, 0);
    chk("mem_write/byteen", {write0, byteen0, write1, byteen1}, 10'b0_1111_0_1111);

    foreach (vecs[k]) begin
      v = vecs[k];
      if (v.tag != 0) for (int i = 0; i < 4; i++) ram0[i] = word_of(v.tag, i);
      start0 = v.st; abort0 = v.ab; ready0 = v.rdy;
      chk($sformatf("row%0d busy", k), busy0, v.busy);
      chk($sformatf("row%0d valid", k), valid0, v.vld);
      chk($sformatf("row%0d done", k), done0, v.done);
      chk($sformatf("row%0d clken/chipsel", k), {clken0, chipsel0}, {v.clken, v.clken});
      if (v.clken) chk($sformatf("row%0d address", k), addr0, v.idx);
      if (v.vld) chk($sformatf("row%0d data/index", k), {index0, data0}, {v.idx, v.dat});
      chk($sformatf("row%0d mem_write", k), write0, 0);
      @(negedge clk);
    end
    start0 = 0; abort0 = 0;

    // continuous mode: word 2 rewritten after sweep 1 has read it
    for (int i = 0; i < 4; i++) ram1[i] = word_of(8'h10, i);
    for (int i = 0; i < 4; i++) e1.push_back({2'(i), word_of(8'h10, i)});
`ifdef POLLER_CHANGE_DETECT_EN
    e1.push_back({2'd2, 32'h55});
`else
    for (int i = 0; i < 4; i++) e1.push_back({2'(i), (i == 2) ? 32'h55 : word_of(8'h10, i)});
`endif
    @(negedge clk); start1 = 1; ready1 = 1;
    @(negedge clk); start1 = 0;
    hs = 0; dn = 0;
    for (int cyc = 0; cyc < 100 && dn < 2; cyc++) begin
      if (valid1) begin
        got1.push_back({index1, data1});
        hs++;
        if (dn == 0 && index1 == 2) ram1[2] = 32'h55;
      end
      if (done1) begin
        dn++;
        chk($sformatf("cont done%0d busy stays", dn), busy1, 1);
        chk($sformatf("cont done%0d after word", dn), hs, (dn == 1) ? 4 : e1.size());
      end
      @(negedge clk);
    end
    chk("cont done count", dn, 2);
    chk("cont word count", got1.size(), e1.size());
    foreach (e1[k]) if (k < got1.size()) chk($sformatf("cont word%0d", k), got1[k], e1[k]);
    abort1 = 1;
    @(negedge clk); abort1 = 0;
    chk("cont abort busy/valid/done", {busy1, valid1, done1}, 0);
    @(negedge clk);
    chk("cont abort stays idle", {busy1, done1}, 0);

    // async reset while dut0 sits in CAPT with a stale nonzero word
    @(negedge clk); start0 = 1; ready0 = 1;
    @(negedge clk); start0 = 0;
    @(negedge clk);
    chk("pre-reset in CAPT", {busy0, clken0, valid0}, 3'b100);
    #2 reset_n = 0;
    #1;
    chk("async reset busy/done/valid", {busy0, done0, valid0}, 0);
    chk("async reset clken/chipsel", {clken0, chipsel0}, 0);
    chk("async reset data", data0, 0);
    chk("async reset index/address", {index0, addr0}, 0);
    @(negedge clk); reset_n = 1;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      chk("post-reset idle", {busy0, valid0, clken0}, 0);
    end

`ifdef POLLER_CHANGE_DETECT_EN
    for (int i = 0; i < 4; i++) ram0[i] = word_of(8'h20, i);
    plan_sweep();
    chk("cd sweep1 planned", exp_q.size(), 4);
    run_sweep0(0, "cd sweep1");
    ram0[1] = 32'hDEAD_0001;
    plan_sweep();
    chk("cd sweep2 planned", exp_q.size(), 1);
    run_sweep0(0, "cd sweep2");
`endif

    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 1) != 0) ram0[i] = $urandom;
      plan_sweep();
      run_sweep0(1, $sformatf("rand%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
